// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared definitions for the PWM ramp controller: state encoding, level width
// and parameter defaults.
package pwm_ramp_ctrl_pkg;

    localparam int LVL_W          = 4;
    localparam int DIV_DEF        = 50000;
    localparam int STEP_TICKS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } state_t;

endpackage

// File: rtl/divisor_tick.sv
// Free-running prescaler: pulses tick for one cycle every DIV clock cycles.
// Reusable by any block that needs a slow enable.
module divisor_tick
    import pwm_ramp_ctrl_pkg::*;
#(
    parameter int DIV = DIV_DEF
) (
    input  logic reloj,
    input  logic reset,
    output logic tick
);

    localparam int PW = $clog2(DIV);

    logic [PW-1:0] cnt;

    assign tick = (cnt == PW'(DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge reloj) begin
        if (reset)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + PW'(1);
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM generator whose duty level ramps one step at a time toward a loaded
// target, changing only at PWM period boundaries.
module pwm_ramp_ctrl
    import pwm_ramp_ctrl_pkg::*;
#(
    parameter int DIV        = DIV_DEF,
    parameter int STEP_TICKS = STEP_TICKS_DEF
) (
    input  logic             reloj,
    input  logic             reset,
    input  logic [7:0]       Ocho,
    input  logic             carga,
    output logic             listo,
    output logic [LVL_W-1:0] nivel,
    output logic             pwm,
    output logic [1:0]       estado
);

    localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

    state_t           state, next_state;
    logic             tick;
    logic [LVL_W-1:0] period;
    logic [LVL_W-1:0] target;
    logic [SW-1:0]    step_cnt;
    logic             boundary, step_ev, load, ramp_start;
    logic             unused_low;

    assign unused_low = ^Ocho[3:0];

    divisor_tick #(.DIV(DIV)) u_div (
        .reloj (reloj),
        .reset (reset),
        .tick  (tick)
    );

    assign boundary   = tick && (period == {LVL_W{1'b1}});
    assign step_ev    = boundary && (step_cnt == SW'(STEP_TICKS - 1));
    assign load       = carga && listo;
    assign ramp_start = load && (next_state != IDLE);

    always_ff @(posedge reloj) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (load) begin
                    if (Ocho[7:4] > nivel)
                        next_state = UP;
                    else if (Ocho[7:4] < nivel)
                        next_state = DOWN;
                end
            end
            UP, DOWN: begin
                if (nivel == target)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        listo  = (state == IDLE);
        estado = state;
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            period   <= '0;
            step_cnt <= '0;
            target   <= '0;
            nivel    <= '0;
            pwm      <= 1'b0;
        end else begin
            if (tick)
                period <= period + LVL_W'(1);

            if (ramp_start)
                step_cnt <= '0;
            else if (step_ev)
                step_cnt <= '0;
            else if (boundary)
                step_cnt <= step_cnt + SW'(1);

            if (load)
                target <= Ocho[7:4];

            // Level only moves on a step event, which always sits on a period boundary.
            if (step_ev && nivel != target) begin
                if (state == UP)
                    nivel <= nivel + LVL_W'(1);
                else if (state == DOWN)
                    nivel <= nivel - LVL_W'(1);
            end

            pwm <= (period < nivel);
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl with DIV=2, STEP_TICKS=1 (one step per
// 32 cycles, steps land on cycle counts that are multiples of 32 after reset).
module tb_pwm_ramp_ctrl;

    typedef struct packed {
        logic [3:0] nivel;
        logic [1:0] estado;
        logic       listo;
    } obs_t;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_UP   = 2'b01;
    localparam logic [1:0] S_DOWN = 2'b10;

    logic       reloj = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] Ocho  = 8'h00;
    logic       carga = 1'b0;
    logic       listo;
    logic [3:0] nivel;
    logic       pwm;
    logic [1:0] estado;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    obs_t sb[$];

    pwm_ramp_ctrl #(.DIV(2), .STEP_TICKS(1)) dut (
        .reloj  (reloj),
        .reset  (reset),
        .Ocho   (Ocho),
        .carga  (carga),
        .listo  (listo),
        .nivel  (nivel),
        .pwm    (pwm),
        .estado (estado)
    );

    always #5 reloj = ~reloj;

    always @(posedge reloj) begin
        if (reset)
            cyc <= 0;
        else
            cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] n, input logic [1:0] e, input logic l);
        obs_t o;
        o.nivel = n; o.estado = e; o.listo = l;
        sb.push_back(o);
    endtask

    // Expected observable sequence for an accepted load from one level to another.
    task automatic push_ramp(input int from, input int to);
        if (to > from) begin
            push(4'(from), S_UP, 1'b0);
            for (int v = from + 1; v <= to; v++) push(4'(v), S_UP, 1'b0);
        end else if (to < from) begin
            push(4'(from), S_DOWN, 1'b0);
            for (int v = from - 1; v >= to; v--) push(4'(v), S_DOWN, 1'b0);
        end
        if (to != from) push(4'(to), S_IDLE, 1'b1);
    endtask

    task automatic pulse_load(input logic [7:0] val);
        @(negedge reloj);
        Ocho  = val;
        carga = 1'b1;
        @(negedge reloj);
        carga = 1'b0;
    endtask

    task automatic wait_for(input logic [3:0] lvl, input logic [1:0] st, input int budget, input string name);
        int n = 0;
        while ((nivel !== lvl || estado !== st) && n < budget) begin
            @(negedge reloj);
            n++;
        end
        check(name, {26'd0, nivel, estado}, {26'd0, lvl, st});
    endtask

    task automatic count_pwm(input int cycles, output int high);
        high = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge reloj);
            if (pwm === 1'b1) high++;
        end
    endtask

    // Monitor: any change of the visible state is an output event to score.
    initial begin
        obs_t prev, cur, exp;
        wait (mon_en);
        prev = {nivel, estado, listo};
        forever begin
            @(negedge reloj);
            cur = {nivel, estado, listo};
            if (cur !== prev) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event: got %0h with empty scoreboard (t=%0t)", cur, $time);
                end else begin
                    exp = sb.pop_front();
                    check("event", 32'(cur), 32'(exp));
                end
                if (cur.nivel !== prev.nivel && !reset)
                    check("step_on_boundary", cyc % 32, 0);
                prev = cur;
            end
        end
    end

    initial begin
        int high;
        int n;

        // Reset, with a carga held during reset that must be ignored.
        @(negedge reloj);
        Ocho  = 8'hF0;
        carga = 1'b1;
        @(negedge reloj);
        carga = 1'b0;
        @(negedge reloj);
        check("rst_nivel",  32'(nivel),  0);
        check("rst_estado", 32'(estado), 32'(S_IDLE));
        check("rst_listo",  32'(listo),  1);
        check("rst_pwm",    32'(pwm),    0);

        reset  = 1'b0;
        mon_en = 1'b1;

        // Level 0: pwm stays low; Ocho changes without carga do nothing.
        Ocho = 8'hFF;
        count_pwm(40, high);
        check("pwm_zero_level", high, 0);
        check("no_load_nivel", 32'(nivel), 0);

        // Full ramp up to 15.
        push_ramp(0, 15);
        pulse_load(8'hF0);
        check("up_listo_low", 32'(listo), 0);
        wait_for(4'd15, S_IDLE, 700, "reach_15");

        // Ramp down to 3, then 3/16 duty.
        push_ramp(15, 3);
        pulse_load(8'h30);
        wait_for(4'd3, S_IDLE, 700, "reach_3");
        count_pwm(32, high);
        check("pwm_duty_3", high, 6);

        // Load ignored while ramping.
        push_ramp(3, 8);
        pulse_load(8'h80);
        wait_for(4'd5, S_UP, 300, "mid_ramp_5");
        pulse_load(8'h00);
        wait_for(4'd8, S_IDLE, 300, "reach_8");

        // Equal target keeps IDLE.
        push_ramp(8, 5);
        pulse_load(8'h50);
        wait_for(4'd5, S_IDLE, 300, "reach_5");
        pulse_load(8'h5A);
        repeat (3) @(negedge reloj);
        check("eq_estado", 32'(estado), 32'(S_IDLE));
        check("eq_listo",  32'(listo),  1);
        check("eq_nivel",  32'(nivel),  5);

        // Reset mid-ramp at 7, then a load in the first cycle after reset.
        push(4'd5, S_UP, 1'b0);
        push(4'd6, S_UP, 1'b0);
        push(4'd7, S_UP, 1'b0);
        pulse_load(8'hF0);
        wait_for(4'd7, S_UP, 300, "mid_ramp_7");
        push(4'd0, S_IDLE, 1'b1);
        reset = 1'b1;
        @(negedge reloj);
        check("mid_rst_nivel", 32'(nivel), 0);
        check("mid_rst_pwm",   32'(pwm),   0);
        check("mid_rst_listo", 32'(listo), 1);
        push_ramp(0, 2);
        reset = 1'b0;
        Ocho  = 8'h20;
        carga = 1'b1;
        @(negedge reloj);
        carga = 1'b0;
        check("post_rst_accept", 32'(estado), 32'(S_UP));
        wait_for(4'd2, S_IDLE, 300, "reach_2");

        // Drain scoreboard.
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge reloj);
            n++;
        end
        repeat (40) @(negedge reloj);
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning clock cycles per PWM tick (DIV >= 2).
REQ-002 SHALL have parameter STEP_TICKS, default 4, meaning PWM periods per ramp step (STEP_TICKS >= 1).
REQ-003 SHALL have port reloj  input  1  meaning the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port Ocho  input  8  meaning target sample from the switches.
REQ-006 SHALL have port carga  input  1  meaning load request for a new target.
REQ-007 SHALL have port listo  output  1  meaning ready; high means a carga is accepted this cycle.
REQ-008 SHALL have port nivel  output  4  meaning current duty level, which drives the LED bar.
REQ-009 SHALL have port pwm  output  1  meaning the PWM output, registered.
REQ-010 SHALL have port estado  output  2  meaning FSM state: IDLE=00, UP=01, DOWN=10.

Function
REQ-011 SHALL generate a one-cycle tick when the prescaler reaches DIV-1, then reload the prescaler to 0.
REQ-012 SHALL advance a 4-bit period counter on each tick, wrapping 15->0; this wrap is the period boundary.
REQ-013 SHALL drive pwm = (period counter < nivel), registered; nivel=0 gives constant 0, and nivel=15 gives 15/16 high.
REQ-014 SHALL quantize the target as Ocho[7:4].
REQ-015 SHALL accept a load only when carga=1 and listo=1 in the same cycle; carga with listo=0 is ignored and not queued.
REQ-016 SHALL drive listo=1 only in IDLE.
REQ-017 On an accepted load, the FSM SHALL take the next state from the target: target>nivel gives UP, target<nivel gives DOWN, target==nivel stays in IDLE with listo still 1.
REQ-018 SHALL count period boundaries in a step counter, 0..STEP_TICKS-1; a step event is a period boundary with step counter = STEP_TICKS-1.
REQ-019 SHALL clear the step counter on entry to UP or DOWN.
REQ-020 In UP, nivel SHALL increment by 1 on each step event.
REQ-021 In DOWN, nivel SHALL decrement by 1 on each step event.
REQ-022 SHALL return the FSM to IDLE in the cycle after nivel equals the target; nivel never passes the target.
REQ-023 SHALL change nivel only at a period boundary, so no PWM period mixes two levels.
REQ-024 SHALL hold nivel constant in IDLE.
REQ-025 SHALL keep nivel within 0..15 with no wrap-around.
REQ-026 SHALL keep Ocho changes without an accepted load from affecting the target.
REQ-027 SHALL run the prescaler and period counter freely in all states.

Reset
REQ-028 SHALL apply reset in the next clock edge while reset=1, overriding everything including a ramp in progress.
REQ-029 Reset values SHALL be: nivel=0, pwm=0, listo=1, estado=IDLE, target=0, prescaler=0, period counter=0, step counter=0.
REQ-030 SHALL ignore carga while reset=1.
REQ-031 SHALL accept carga in the first cycle after reset deasserts.

Structure
REQ-032 SHALL put in a shared package: the state encoding constants (IDLE, UP, DOWN), level width 4, and DIV and STEP_TICKS defaults.
REQ-033 SHALL implement the prescaler in one sub-module, divisor_tick, with ports reloj, reset and tick; it is reusable by other blocks.
REQ-034 SHALL keep the FSM, counters and comparator in pwm_ramp_ctrl.

Verification (DIV=2, STEP_TICKS=1)
REQ-035 Scenario: reset, then Ocho=8'hF0 with carga pulsed one cycle -> listo=0; estado=UP; nivel steps 0->15, one step per 32 cycles, at period boundaries only; then estado=IDLE and listo=1.
REQ-036 Scenario: at nivel=15, load Ocho=8'h30 -> estado=DOWN; nivel steps down to 3 and stops; pwm is high 3 of every 16 ticks.
REQ-037 Scenario: mid-ramp UP, pulse carga with Ocho=8'h00 -> request ignored; ramp completes to the original target.
REQ-038 Scenario: in IDLE at nivel=5, load Ocho=8'h5A -> estado stays IDLE; listo stays 1; nivel=5.
REQ-039 Scenario: assert reset mid-ramp at nivel=7 -> next edge gives nivel=0, pwm=0, estado=IDLE, listo=1; carga in the first post-reset cycle is accepted.
REQ-040 Scenario: nivel=0 -> pwm constantly 0; Ocho=8'hFF with no carga -> nivel unchanged.
